// File: rtl/mem_bank_arb_pkg.sv
// mem_bank_arb_pkg: shared widths and helpers for the memory bank round-robin arbiter
package mem_bank_arb_pkg;
  localparam int PerfCntWidth = 16;
  localparam int AtopWidth = 6;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/mem_bank_arb_idx_fifo.sv
// mem_bank_arb_idx_fifo: requester-index FIFO tracking outstanding bank requests in order
module mem_bank_arb_idx_fifo
  import mem_bank_arb_pkg::*;
#(
  parameter int Depth = 2,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = idx_width(Depth);
  localparam int CntW = $clog2(Depth + 1);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full_o = cnt_q == CntW'(Depth);
  assign empty_o = cnt_q == '0;
  assign do_pop = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot, so pushing into a full FIFO is legal then
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/mem_bank_rr_arbiter.sv
// mem_bank_rr_arbiter: round-robin share of one memory bank with in-order response routing
// Optional per-requester grant counters enabled by defining MEM_BANK_ARB_PERF_EN.
module mem_bank_rr_arbiter
  import mem_bank_arb_pkg::*;
#(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int RespDepth = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReq-1:0]                 req_i,
  output logic [NumReq-1:0]                 gnt_o,
  input  logic [NumReq*AddrWidth-1:0]       addr_i,
  input  logic [NumReq*DataWidth-1:0]       wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]     strb_i,
  input  logic [NumReq-1:0]                 we_i,
  input  logic [NumReq*6-1:0]               atop_i,
  output logic [NumReq-1:0]                 rvalid_o,
  output logic [DataWidth-1:0]              rdata_o,
  output logic                              mem_req_o,
  input  logic                              mem_gnt_i,
  output logic [AddrWidth-1:0]              mem_addr_o,
  output logic [DataWidth-1:0]              mem_wdata_o,
  output logic [DataWidth/8-1:0]            mem_strb_o,
  output logic                              mem_we_o,
  output logic [5:0]                        mem_atop_o,
  input  logic                              mem_rvalid_i,
  input  logic [DataWidth-1:0]              mem_rdata_i,
  output logic                              busy_o,
  output logic                              err_o,
  output logic [NumReq*PerfCntWidth-1:0]    perf_cnt_o
);
  localparam int IdxW = idx_width(NumReq);
  localparam int StrbW = strb_width(DataWidth);
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbW-1:0] strb_t;
  logic [IdxW-1:0] rr_ptr_q, winner, head;
  logic full, empty, can_issue, grant, pop, err_q;
  int j;
  // scan downwards so the last hit is the first requester at or after rr_ptr_q
  always_comb begin
    winner = rr_ptr_q;
    j = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = (int'(rr_ptr_q) + k) % NumReq;
      if (req_i[j]) winner = IdxW'(j);
    end
  end
  assign can_issue = ~full | mem_rvalid_i;
  assign mem_req_o = |req_i & can_issue;
  assign grant = mem_req_o & mem_gnt_i;
  assign gnt_o = grant ? NumReq'(1) << winner : '0;
  assign mem_addr_o = addr_t'(addr_i[winner*AddrWidth +: AddrWidth]);
  assign mem_wdata_o = data_t'(wdata_i[winner*DataWidth +: DataWidth]);
  assign mem_strb_o = strb_t'(strb_i[winner*StrbW +: StrbW]);
  assign mem_we_o = we_i[winner];
  assign mem_atop_o = atop_i[winner*AtopWidth +: AtopWidth];
  assign pop = mem_rvalid_i & ~empty;
  assign rvalid_o = pop ? NumReq'(1) << head : '0;
  assign rdata_o = mem_rdata_i;
  assign busy_o = ~empty;
  assign err_o = err_q;
  mem_bank_arb_idx_fifo #(.Depth(RespDepth), .Width(IdxW)) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .data_i  (winner),
    .pop_i   (mem_rvalid_i),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant) rr_ptr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
      if (mem_rvalid_i & empty) err_q <= 1'b1;
    end
  end
`ifdef MEM_BANK_ARB_PERF_EN
  for (genvar i = 0; i < NumReq; i++) begin : g_perf
    logic [PerfCntWidth-1:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else if (gnt_o[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign perf_cnt_o[i*PerfCntWidth +: PerfCntWidth] = cnt_q;
  end
`else
  assign perf_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mem_bank_rr_arbiter.sv
// tb_mem_bank_rr_arbiter: randomized and directed checks against a queue-based reference model
module tb_mem_bank_rr_arbiter;
  localparam int N = 4, AW = 32, DW = 64, SW = 8, D = 2;
  logic clk = 0, rst_i = 0;
  logic [N-1:0] req_i = '0, gnt_o, we_i = '0, rvalid_o;
  logic [N*AW-1:0] addr_i = '0;
  logic [N*DW-1:0] wdata_i = '0;
  logic [N*SW-1:0] strb_i = '0;
  logic [N*6-1:0] atop_i = '0;
  logic [DW-1:0] rdata_o, mem_wdata_o, mem_rdata_i = '0;
  logic mem_req_o, mem_gnt_i = 0, mem_we_o, mem_rvalid_i = 0, busy_o, err_o;
  logic [AW-1:0] mem_addr_o;
  logic [SW-1:0] mem_strb_o;
  logic [5:0] mem_atop_o;
  logic [N*16-1:0] perf_cnt_o;
  always #5 clk = ~clk;
  mem_bank_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .RespDepth(D)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .we_i(we_i), .atop_i(atop_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_we_o(mem_we_o), .mem_atop_o(mem_atop_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .err_o(err_o), .perf_cnt_o(perf_cnt_o)
  );
  int n_checks = 0, n_errs = 0;
  int own_q[$], due_q[$], gnt_log[$];
  logic [63:0] dat_q[$];
  int m_ptr = 0, cyc = 0, lat = 1, gnt_pct = 100;
  int m_perf[N];
  bit m_err = 0, orphan = 0, keep_data = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic [N-1:0] req);
    bit rv, any, can, mreq, g;
    logic [63:0] rd, pe;
    logic [N-1:0] eg, er;
    int w;
    @(posedge clk);
    #1;
    cyc++;
    req_i = req;
    if (!keep_data)
      for (int i = 0; i < N; i++) begin
        addr_i[i*AW +: AW] = $urandom;
        wdata_i[i*DW +: DW] = {$urandom, $urandom};
        strb_i[i*SW +: SW] = 8'($urandom);
        we_i[i] = 1'($urandom);
        atop_i[i*6 +: 6] = 6'($urandom);
      end
    mem_gnt_i = $urandom_range(99) < gnt_pct;
    rd = {$urandom, $urandom};
    rv = orphan && due_q.size() == 0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      rv = 1;
      rd = dat_q[0];
      void'(due_q.pop_front());
      void'(dat_q.pop_front());
    end
    mem_rvalid_i = rv;
    mem_rdata_i = rd;
    #1;
    any = |req;
    w = -1;
    for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    can = own_q.size() < D || rv;
    mreq = any && can;
    g = mreq && mem_gnt_i;
    eg = g ? N'(1) << w : '0;
    chk("mem_req", 64'(mem_req_o), 64'(mreq));
    chk("gnt", 64'(gnt_o), 64'(eg));
    if (any) begin
      chk("addr", 64'(mem_addr_o), 64'(addr_i[w*AW +: AW]));
      chk("wdata", mem_wdata_o, wdata_i[w*DW +: DW]);
      chk("strb", 64'(mem_strb_o), 64'(strb_i[w*SW +: SW]));
      chk("we", 64'(mem_we_o), 64'(we_i[w]));
      chk("atop", 64'(mem_atop_o), 64'(atop_i[w*6 +: 6]));
    end
    er = (rv && own_q.size() > 0) ? N'(1) << own_q[0] : '0;
    chk("rvalid", 64'(rvalid_o), 64'(er));
    if (rv) chk("rdata", rdata_o, rd);
    chk("busy", 64'(busy_o), 64'(own_q.size() != 0));
    chk("err", 64'(err_o), 64'(m_err));
    pe = '0;
`ifdef MEM_BANK_ARB_PERF_EN
    for (int i = 0; i < N; i++) pe[i*16 +: 16] = 16'(m_perf[i]);
`endif
    chk("perf", perf_cnt_o, pe);
    if (g) gnt_log.push_back(w);
    if (rv) begin
      if (own_q.size() > 0) void'(own_q.pop_front());
      else m_err = 1;
    end
    if (g) begin
      own_q.push_back(w);
      m_ptr = (w + 1) % N;
      due_q.push_back(cyc + lat);
      dat_q.push_back({$urandom, $urandom});
      if (m_perf[w] < 65535) m_perf[w]++;
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_i = 1;
    req_i = '0;
    mem_rvalid_i = 0;
    mem_gnt_i = 0;
    #1;
    chk("busy_rst", 64'(busy_o), 64'(0));
    chk("err_rst", 64'(err_o), 64'(0));
    own_q.delete();
    m_ptr = 0;
    m_err = 0;
    for (int i = 0; i < N; i++) m_perf[i] = 0;
    @(posedge clk);
    #1;
    rst_i = 0;
  endtask
  initial begin
    int e1[5] = '{0, 1, 2, 3, 0};
    int drops;
    for (int i = 0; i < N; i++) m_perf[i] = 0;
    do_reset();
    repeat (3) cycle('0);
    gnt_log.delete();
    repeat (5) cycle(4'b1111);
    repeat (2) cycle('0);
    chk("rr_cnt", 64'(gnt_log.size()), 64'(5));
    for (int k = 0; k < 5 && k < gnt_log.size(); k++) chk("rr_order", 64'(gnt_log[k]), 64'(e1[k]));
    gnt_log.delete();
    repeat (2) cycle(4'b0101);
    repeat (2) cycle('0);
    chk("skip_cnt", 64'(gnt_log.size()), 64'(2));
    if (gnt_log.size() == 2) begin
      chk("skip_first", 64'(gnt_log[0]), 64'(2));
      chk("skip_second", 64'(gnt_log[1]), 64'(0));
    end
    lat = 3;
    drops = 0;
    repeat (12) begin
      cycle(4'b1111);
      if (!mem_req_o) drops++;
    end
    chk("backpressure", 64'(drops > 0), 64'(1));
    repeat (5) cycle('0);
    lat = 1;
    keep_data = 1;
    addr_i[3*AW +: AW] = 32'h40;
    wdata_i[3*DW +: DW] = 64'hDEAD_BEEF;
    strb_i[3*SW +: SW] = 8'h0F;
    we_i[3] = 1;
    atop_i[3*6 +: 6] = '0;
    cycle(4'b1000);
    chk("wr_addr", 64'(mem_addr_o), 64'h40);
    chk("wr_data", mem_wdata_o, 64'hDEAD_BEEF);
    chk("wr_strb", 64'(mem_strb_o), 64'h0F);
    chk("wr_we", 64'(mem_we_o), 64'(1));
    cycle('0);
    chk("wr_rvalid", 64'(rvalid_o), 64'b1000);
    keep_data = 0;
    repeat (2) cycle('0);
    orphan = 1;
    cycle('0);
    chk("orphan_rvalid", 64'(rvalid_o), 64'(0));
    orphan = 0;
    repeat (3) cycle('0);
    chk("orphan_err", 64'(err_o), 64'(1));
    do_reset();
    lat = 3;
    repeat (2) cycle(4'b1111);
    chk("busy_pre", 64'(busy_o), 64'(1));
    do_reset();
    repeat (5) cycle('0);
    chk("stale_err", 64'(err_o), 64'(1));
    do_reset();
    due_q.delete();
    dat_q.delete();
    for (int p = 0; p < 8; p++) begin
      lat = $urandom_range(1, 4);
      gnt_pct = $urandom_range(40, 100);
      repeat (150) cycle(N'($urandom));
      gnt_pct = 100;
      repeat (8) cycle('0);
    end
`ifdef MEM_BANK_ARB_PERF_EN
    do_reset();
    lat = 1;
    repeat (70000) cycle(4'b0001);
    chk("perf_sat", 64'(perf_cnt_o[15:0]), 64'hFFFF);
`else
    chk("perf_off", perf_cnt_o, 64'(0));
`endif
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
